// File: rtl/sw_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : sw_pkg                                                 |
// | Shared state encoding and default sizing for the switch          |
// | conditioner.                                                     |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
package sw_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    RISE_WAIT = 2'd1,
    HIGH      = 2'd2,
    FALL_WAIT = 2'd3
  } sw_state_t;

  // 10 ms debounce and 1 s long-press window at 12 MHz
  localparam int SW_DEBOUNCE_CYCLES = 120000;
  localparam int SW_LONG_CYCLES     = 12000000;
  localparam int SW_CNT_W           = 24;

endpackage
`default_nettype wire

// File: rtl/sw_conditioner_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Interface : sw_conditioner_if                                    |
// | Raw switch pin in, conditioned level and strobes out.            |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
interface sw_conditioner_if;
  logic i_sw_raw;
  logic o_sw_level;
  logic o_press;
  logic o_release;
  logic o_long_press;
  logic o_toggle;

  // Driver of the pin and consumer of the conditioned outputs
  modport master (
    output i_sw_raw,
    input  o_sw_level, o_press, o_release, o_long_press, o_toggle
  );

  // The conditioner itself
  modport slave (
    input  i_sw_raw,
    output o_sw_level, o_press, o_release, o_long_press, o_toggle
  );
endinterface
`default_nettype wire

// File: rtl/sw_conditioner_sync2.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : sync2                                                  |
// | Two-flop synchroniser for one asynchronous bit, resets to 0.     |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module sync2 (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_d,
  output logic      o_q
);
  logic r_s1;
  logic r_s2;

  // Shift the asynchronous input through two flops to settle metastability
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;
endmodule
`default_nettype wire

// File: rtl/sw_conditioner.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : sw_conditioner                                         |
// | Synchronises and debounces a raw switch pin; produces a stable   |
// | level, press/release/long-press strobes and a press toggle.      |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module sw_conditioner
  import sw_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = SW_LONG_CYCLES,
  parameter int CNT_W           = SW_CNT_W
) (
  input wire logic         clk,
  input wire logic         rst_n,
  sw_conditioner_if.slave  bus
);

  localparam logic [CNT_W-1:0] c_DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);
  // With a one-cycle debounce the first differing sample is accepted directly
  localparam bit               c_DB_ONE    = (DEBOUNCE_CYCLES == 1);

  logic             w_sw_s;
  sw_state_t        r_state;
  logic [CNT_W-1:0] r_db_cnt;
  logic [CNT_W-1:0] r_hold_cnt;
  logic             r_long_done;
  logic             r_level;
  logic             r_press;
  logic             r_release;
  logic             r_long;
  logic             r_toggle;

  sync2 u_sync2 (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (bus.i_sw_raw),
    .o_q   (w_sw_s)
  );

  // Debounce FSM with both counters and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= LOW;
      r_db_cnt    <= '0;
      r_hold_cnt  <= '0;
      r_long_done <= 1'b0;
      r_level     <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_long      <= 1'b0;
      r_toggle    <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;

      unique case (r_state)
        LOW: begin
          if (w_sw_s) begin
            if (c_DB_ONE) begin
              r_state     <= HIGH;
              r_level     <= 1'b1;
              r_press     <= 1'b1;
              r_toggle    <= ~r_toggle;
              r_hold_cnt  <= '0;
              r_long_done <= 1'b0;
              r_db_cnt    <= '0;
            end else begin
              r_state  <= RISE_WAIT;
              r_db_cnt <= c_ONE;
            end
          end
        end

        RISE_WAIT: begin
          if (!w_sw_s) begin
            r_state  <= LOW;
            r_db_cnt <= '0;
          end else if (r_db_cnt == c_DB_LAST) begin
            r_state     <= HIGH;
            r_level     <= 1'b1;
            r_press     <= 1'b1;
            r_toggle    <= ~r_toggle;
            r_hold_cnt  <= '0;
            r_long_done <= 1'b0;
            r_db_cnt    <= '0;
          end else begin
            r_db_cnt <= r_db_cnt + c_ONE;
          end
        end

        HIGH: begin
          // Hold window: count up, then fire once and saturate
          if (r_hold_cnt < c_LONG_LAST) begin
            r_hold_cnt <= r_hold_cnt + c_ONE;
          end else if (!r_long_done && !(c_DB_ONE && !w_sw_s)) begin
            r_long      <= 1'b1;
            r_long_done <= 1'b1;
          end
          if (!w_sw_s) begin
            if (c_DB_ONE) begin
              r_state   <= LOW;
              r_level   <= 1'b0;
              r_release <= 1'b1;
              r_db_cnt  <= '0;
            end else begin
              r_state  <= FALL_WAIT;
              r_db_cnt <= c_ONE;
            end
          end
        end

        FALL_WAIT: begin
          // Keep the hold window running so a release bounce cannot restart it
          if (r_hold_cnt < c_LONG_LAST) begin
            r_hold_cnt <= r_hold_cnt + c_ONE;
          end
          if (w_sw_s) begin
            r_state  <= HIGH;
            r_db_cnt <= '0;
          end else if (r_db_cnt == c_DB_LAST) begin
            r_state   <= LOW;
            r_level   <= 1'b0;
            r_release <= 1'b1;
            r_db_cnt  <= '0;
          end else begin
            r_db_cnt <= r_db_cnt + c_ONE;
          end
        end

        default: begin
          r_state  <= LOW;
          r_db_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.o_sw_level   = r_level;
  assign bus.o_press      = r_press;
  assign bus.o_release    = r_release;
  assign bus.o_long_press = r_long;
  assign bus.o_toggle     = r_toggle;

endmodule
`default_nettype wire
